// File: rtl/serial_frame_shifter_if.sv
// Load/abort request and serial-output bundle between a frame source and the shifter.
interface serial_frame_shifter_if #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
);
  logic             load;
  logic [WIDTH-1:0] data_in;
  logic [LEN_W-1:0] len;
  logic             abort;
  logic             x;
  logic             x_valid;
  logic             ready;
  logic             busy;
  logic             done;
  logic             len_err;
  logic [7:0]       frame_cnt;

  modport master (
    output load, data_in, len, abort,
    input  x, x_valid, ready, busy, done, len_err, frame_cnt
  );

  modport slave (
    input  load, data_in, len, abort,
    output x, x_valid, ready, busy, done, len_err, frame_cnt
  );
endinterface

// File: rtl/serial_frame_shifter.sv
// Parallel-to-serial frame source: shifts the low len bits of a word out MSB-first,
// one bit per clock, with a registered valid flag and a one-cycle done pulse.
module serial_frame_shifter #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 4
) (
  input logic                  CLK,
  input logic                  RESET,
  serial_frame_shifter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, SHIFT = 2'b01, DONE = 2'b10} state_t;

  localparam logic [LEN_W-1:0] WL = LEN_W'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             done_q, done_d;
  logic             lerr_q, lerr_d;
  logic [7:0]       fcnt_q, fcnt_d;
  logic [LEN_W-1:0] eff_len;
  logic [WIDTH-1:0] loaded;

  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    x_d     = 1'b0;
    xv_d    = 1'b0;
    done_d  = 1'b0;
    lerr_d  = 1'b0;
    fcnt_d  = fcnt_q;
    // Oversized lengths clamp silently; the word is left-aligned so the MSB is always next out.
    eff_len = (bus.len > WL) ? WL : bus.len;
    loaded  = bus.data_in << (WL - eff_len);
    case (state_q)
      IDLE: begin
        if (bus.load) begin
          if (bus.len == '0) begin
            lerr_d = 1'b1;
          end else begin
            sreg_d  = loaded;
            cnt_d   = eff_len;
            x_d     = loaded[WIDTH-1];
            xv_d    = 1'b1;
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        if (bus.abort) begin
          sreg_d  = '0;
          cnt_d   = '0;
          state_d = IDLE;
        end else if (cnt_q <= LEN_W'(1)) begin
          sreg_d  = '0;
          cnt_d   = '0;
          done_d  = 1'b1;
          fcnt_d  = fcnt_q + 8'd1;
          state_d = DONE;
        end else begin
          sreg_d = sreg_q << 1;
          cnt_d  = cnt_q - LEN_W'(1);
          x_d    = sreg_d[WIDTH-1];
          xv_d   = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      xv_q    <= 1'b0;
      done_q  <= 1'b0;
      lerr_q  <= 1'b0;
      fcnt_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
      done_q  <= done_d;
      lerr_q  <= lerr_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign bus.x         = x_q;
  assign bus.x_valid   = xv_q;
  assign bus.ready     = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.len_err   = lerr_q;
  assign bus.frame_cnt = fcnt_q;
endmodule

// File: tb/tb_serial_frame_shifter.sv
// Scoreboarded bench: expected serial bits queued at load, popped on every valid output cycle.
module tb_serial_frame_shifter;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] exp_cnt = 8'd0;
  logic exp_q[$];

  serial_frame_shifter_if #(.WIDTH(8), .LEN_W(4)) bus ();
  serial_frame_shifter #(.WIDTH(8), .LEN_W(4)) dut (.CLK(CLK), .RESET(RESET), .bus(bus));

  always #5 CLK = ~CLK;

  // Bit monitor: every valid cycle must match the next queued bit; idle cycles must hold x low.
  always @(negedge CLK) begin
    if (!RESET) begin
      if (bus.x_valid === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL bit_unexpected: x=%b with x_valid=1, required no valid bit", bus.x);
        end else begin
          logic e;
          e = exp_q.pop_front();
          if (bus.x !== e) begin
            fails++;
            $display("FAIL bit_value: x=%b, required %b", bus.x, e);
          end
        end
      end else if (bus.x !== 1'b0) begin
        tests++;
        fails++;
        $display("FAIL x_idle: x=%b x_valid=%b, required x=0", bus.x, bus.x_valid);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation time limit reached, required completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  function automatic int eff(input logic [3:0] l);
    return (l > 4'd8) ? 8 : int'(l);
  endfunction

  task automatic start(input logic [7:0] d, input logic [3:0] l);
    @(negedge CLK);
    bus.load = 1'b1; bus.data_in = d; bus.len = l;
    for (int i = eff(l) - 1; i >= 0; i--) exp_q.push_back(d[i]);
    @(negedge CLK);
    bus.load = 1'b0;
  endtask

  // Called from the cycle after bit 0 is shown; n more cycles reach the done cycle.
  task automatic finish(input int n, input string nm);
    repeat (n) @(negedge CLK);
    exp_cnt = exp_cnt + 8'd1;
    tests++;
    if (bus.done !== 1'b1 || bus.x_valid !== 1'b0 || bus.frame_cnt !== exp_cnt || exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_done: done=%b x_valid=%b cnt=%0d left=%0d, required done=1 x_valid=0 cnt=%0d left=0",
               nm, bus.done, bus.x_valid, bus.frame_cnt, exp_q.size(), exp_cnt);
    end
    @(negedge CLK);
    tests++;
    if (bus.done !== 1'b0 || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL %s_idle: done=%b ready=%b busy=%b, required 0 1 0", nm, bus.done, bus.ready, bus.busy);
    end
  endtask

  task automatic test_reset;
    RESET = 1'b1; bus.load = 1'b1; bus.data_in = 8'hFF; bus.len = 4'd8; bus.abort = 1'b0;
    repeat (2) @(negedge CLK);
    tests++;
    if (bus.x !== 0 || bus.x_valid !== 0 || bus.ready !== 1 || bus.busy !== 0 || bus.frame_cnt !== 0 ||
        bus.done !== 0 || bus.len_err !== 0) begin
      fails++;
      $display("FAIL reset_vals: x=%b xv=%b rdy=%b busy=%b cnt=%0d done=%b lerr=%b, required 0 0 1 0 0 0 0",
               bus.x, bus.x_valid, bus.ready, bus.busy, bus.frame_cnt, bus.done, bus.len_err);
    end
    RESET = 1'b0; bus.load = 1'b0;
    @(negedge CLK);
    tests++;
    if (bus.x_valid !== 0 || bus.ready !== 1) begin
      fails++;
      $display("FAIL reset_nostart: x_valid=%b ready=%b, required 0 1", bus.x_valid, bus.ready);
    end
  endtask

  task automatic test_basic;
    start(8'h0D, 4'd4);
    finish(4, "basic");
  endtask

  task automatic test_ignore_load;
    start(8'hB5, 4'd8);
    @(negedge CLK);
    bus.load = 1'b1; bus.data_in = 8'hFF; bus.len = 4'd8;
    @(negedge CLK);
    bus.load = 1'b0;
    repeat (5) @(negedge CLK);
    tests++;
    if (bus.ready !== 1'b0 || bus.x_valid !== 1'b1) begin
      fails++;
      $display("FAIL ignore_last_bit: ready=%b x_valid=%b, required 0 1", bus.ready, bus.x_valid);
    end
    finish(1, "ignore");
  endtask

  task automatic test_len_err_clamp;
    @(negedge CLK);
    bus.load = 1'b1; bus.data_in = 8'hAA; bus.len = 4'd0;
    @(negedge CLK);
    bus.load = 1'b0;
    tests++;
    if (bus.len_err !== 1'b1 || bus.ready !== 1'b1 || bus.x_valid !== 1'b0) begin
      fails++;
      $display("FAIL len_err_pulse: len_err=%b ready=%b xv=%b, required 1 1 0", bus.len_err, bus.ready, bus.x_valid);
    end
    @(negedge CLK);
    tests++;
    if (bus.len_err !== 1'b0) begin
      fails++;
      $display("FAIL len_err_clear: len_err=%b, required 0", bus.len_err);
    end
    start(8'hFF, 4'd12);
    finish(8, "clamp");
  endtask

  task automatic test_abort;
    start(8'h0D, 4'd4);
    @(negedge CLK);
    bus.abort = 1'b1;
    @(negedge CLK);
    bus.abort = 1'b0;
    exp_q.delete();
    tests++;
    if (bus.x_valid !== 0 || bus.ready !== 1 || bus.done !== 0 || bus.frame_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL abort_idle: xv=%b rdy=%b done=%b cnt=%0d, required 0 1 0 %0d",
               bus.x_valid, bus.ready, bus.done, bus.frame_cnt, exp_cnt);
    end
    repeat (3) @(negedge CLK);
    tests++;
    if (bus.done !== 0 || bus.frame_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL abort_nodone: done=%b cnt=%0d, required 0 %0d", bus.done, bus.frame_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid;
    start(8'h0D, 4'd4);
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1 exp_q.delete();
    @(negedge CLK);
    RESET = 1'b0;
    exp_cnt = 8'd0;
    tests++;
    if (bus.x !== 0 || bus.x_valid !== 0 || bus.ready !== 1 || bus.busy !== 0 || bus.frame_cnt !== 0 || bus.done !== 0) begin
      fails++;
      $display("FAIL reset_mid: x=%b xv=%b rdy=%b busy=%b cnt=%0d done=%b, required 0 0 1 0 0 0",
               bus.x, bus.x_valid, bus.ready, bus.busy, bus.frame_cnt, bus.done);
    end
  endtask

  task automatic test_wrap;
    for (int f = 0; f < 256; f++) begin
      logic [7:0] d;
      logic [3:0] l;
      d = 8'($urandom);
      l = 4'($urandom_range(1, 8));
      start(d, l);
      finish(eff(l), "wrap");
    end
    tests++;
    if (bus.frame_cnt !== 8'd0) begin
      fails++;
      $display("FAIL wrap_cnt: frame_cnt=%0d, required 0", bus.frame_cnt);
    end
  endtask

  task automatic test_back_to_back;
    @(negedge CLK);
    bus.load = 1'b1; bus.data_in = 8'h0D; bus.len = 4'd4;
    for (int r = 0; r < 2; r++) for (int i = 3; i >= 0; i--) exp_q.push_back(bus.data_in[i]);
    repeat (5) @(negedge CLK);
    exp_cnt = exp_cnt + 8'd1;
    tests++;
    if (bus.done !== 1'b1 || bus.frame_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL b2b_done1: done=%b cnt=%0d, required 1 %0d", bus.done, bus.frame_cnt, exp_cnt);
    end
    @(negedge CLK);
    tests++;
    if (bus.x_valid !== 1'b0 || bus.ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_gap: xv=%b ready=%b, required 0 1", bus.x_valid, bus.ready);
    end
    @(negedge CLK);
    bus.load = 1'b0;
    tests++;
    if (bus.x_valid !== 1'b1 || bus.busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_restart: xv=%b busy=%b, required 1 1", bus.x_valid, bus.busy);
    end
    finish(4, "b2b");
  endtask

  initial begin
    bus.load = 1'b0; bus.data_in = '0; bus.len = '0; bus.abort = 1'b0;
    test_reset();
    test_basic();
    test_ignore_load();
    test_len_err_clamp();
    test_abort();
    test_reset_mid();
    test_wrap();
    test_back_to_back();
    repeat (2) @(negedge CLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/serial_frame_shifter.md
Name: serial_frame_shifter

Overview:
- Parallel-to-serial source that drives the `x` input of the 1101 sequence-detector FSM (`fsm_implementation`).
- Accepts a WIDTH-bit word and a bit length through a load strobe. Shifts the low `len` bits out MSB-first, one bit per clock. Flags valid bits and signals frame completion.
- Replaces hand-written bench stimulus with a reusable, synthesizable stimulus/transmit stage.

Parameters:
- WIDTH, 8, maximum frame length in bits (width of data_in).
- LEN_W, 4, width of len input; must satisfy WIDTH <= 2**LEN_W - 1.

Ports:
- CLK  input  1  system clock, all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- load  input  1  request to start a frame; sampled only when ready=1.
- data_in  input  WIDTH  frame bits; bit len-1 transmitted first, bit 0 last.
- len  input  LEN_W  number of bits to transmit.
- abort  input  1  cancel the frame in progress.
- x  output  1  serial bit to the downstream FSM (registered).
- x_valid  output  1  x carries a frame bit this cycle (registered).
- ready  output  1  high in IDLE only; load is accepted.
- busy  output  1  high when state != IDLE.
- done  output  1  one-cycle pulse after the last bit of a completed frame (registered).
- len_err  output  1  one-cycle pulse when load is seen with len=0 (registered).
- frame_cnt  output  8  count of completed frames, wraps 255 -> 0.

Behaviour:
- Only one clock and one reset. RESET is synchronous and active-high and has priority over all other inputs.
- Reset values:
  - state=IDLE, x=0, x_valid=0, done=0, len_err=0, frame_cnt=0.
  - Internal shift register and bit counter are 0.
  - Hence ready=1 and busy=0 on the cycle after the reset edge.
- States: IDLE, SHIFT, DONE (2-bit encoding 00/01/10; 11 recovers to IDLE).
- IDLE:
  - load=1 and len>=1: the shift register loads data_in left-aligned, shifted by WIDTH-eff_len.
    - eff_len = min(len, WIDTH); len>WIDTH is clamped to WIDTH with no error.
    - bit counter = eff_len; next state is SHIFT.
    - On the same edge, x = data_in[eff_len-1] and x_valid=1.
  - load=1 and len=0: stay in IDLE and pulse len_err=1 for one cycle. x and x_valid stay 0.
  - load=0: stay in IDLE with x=0 and x_valid=0.
- SHIFT:
  - Each edge shifts the register left by one, decrements the counter, and presents the next bit on x with x_valid=1.
  - The edge on which the counter reaches its final bit moves to DONE: x=0, x_valid=0, done=1.
- Latency:
  - A load sampled at edge k puts bit eff_len-1-i on x during the cycle after edge k+i, for i=0..eff_len-1.
  - done is high during the cycle after edge k+eff_len.
  - frame_cnt increments at that same edge.
- DONE: lasts exactly one cycle, then IDLE; done returns to 0.
  - Earliest next accepted load is at edge k+eff_len+2 (back-to-back frames have a 2-cycle gap with x=0).
- Ignored inputs:
  - load in SHIFT or DONE: ignored, not queued.
  - abort in IDLE or DONE: ignored.
  - load and abort together in IDLE: load accepted.
- abort=1 in SHIFT: next edge goes to IDLE with x=0 and x_valid=0. No done pulse and no frame_cnt change.
- RESET mid-frame: all outputs and state return to reset values on that edge. frame_cnt clears.
- x is held at 0 whenever x_valid=0. The downstream detector therefore sees a 0 between frames, which resets its partial-match progress.

Test Plan:
- RESET high 2 cycles with load=1 -> x=0, x_valid=0, ready=1, busy=0, frame_cnt=0, and no frame is started.
- load with data_in=8'h0D, len=4 -> x=1,1,0,1 on 4 consecutive cycles with x_valid=1, then done=1 for 1 cycle and frame_cnt=1. Downstream fsm_implementation asserts Z for the final 1.
- load with data_in=8'hB5, len=8, plus load with 8'hFF pulsed mid-frame -> x=1,0,1,1,0,1,0,1; the second load is ignored; ready goes high 2 cycles after the last bit.
- len=0 -> len_err pulses once, state stays IDLE. Then data_in=8'hFF, len=12 -> exactly 8 ones followed by done.
- data_in=8'h0D, len=4, abort asserted after 2 bits -> IDLE next edge, x_valid=0, no done, frame_cnt unchanged.
- RESET asserted during the 3rd bit of a frame -> reset values on the next edge. Then run 256 complete frames -> frame_cnt wraps to 0.
